// File: rtl/definesPkg.sv
// Shared register-file dimensions for the decode/writeback datapath.
// No logic: constants only.
// Consumers derive their address width from NREGS the same way as REG_AW.
package definesPkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 8;
  localparam int REG_AW = $clog2(NREGS);

endpackage

// File: rtl/regfile_scoreboard_sb_counter.sv
// Per-register pending-write counter: counts issued writes not yet written back.
// State visible one cycle after inc/dec; full/dec_hit/underflow are combinational.
// Caller must not assert inc while full unless a decrement lands in the same cycle.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec_req,
  output logic [CNT_W-1:0] cnt,
  output logic             dec_hit,
  output logic             full,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // A writeback only retires an outstanding write if one exists.
  assign dec_hit   = dec_req && (cnt != '0);
  assign underflow = dec_req && (cnt == '0);
  assign full      = (cnt == CNT_MAX);

  // Coincident inc and dec cancel; the full guard keeps the count from wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (inc && !dec_hit && !full) begin
      cnt <= cnt + CNT_W'(1);
    end else if (dec_hit && !inc) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with writeback bypass plus a pending-write scoreboard for decode.
// Reads and o_stall are combinational; writes and counts update on the next edge.
// o_stall holds decode when a source is still in flight or a counter would overflow.
module regfile_scoreboard #(
  parameter int DATA_W = definesPkg::DATA_W,
  parameter int NREGS  = definesPkg::NREGS,
  parameter int CNT_W  = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RFWrite,
  input  logic [AW-1:0]     regw,
  input  logic [DATA_W-1:0] dataw,
  input  logic [AW-1:0]     ra,
  input  logic [AW-1:0]     rb,
  input  logic              use_a,
  input  logic              use_b,
  input  logic              issue_valid,
  input  logic              issue_wr,
  input  logic [AW-1:0]     issue_rd,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              o_stall,
  output logic              o_err
);

  logic [DATA_W-1:0]           regs [NREGS];
  logic [NREGS-1:0][CNT_W-1:0] pend;
  logic [NREGS-1:0]            dec_hit;
  logic [NREGS-1:0]            full;
  logic [NREGS-1:0]            underflow;
  logic                        accept;
  logic                        haz_a;
  logic                        haz_b;
  logic                        haz_sat;
  logic [CNT_W-1:0]            thr_a;
  logic [CNT_W-1:0]            thr_b;

  // Register array: writeback lands on the edge, reset clears everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (RFWrite) begin
      regs[regw] <= dataw;
    end
  end

  // Combinational reads, forwarding the writeback in flight this cycle.
  always_comb begin
    rd1 = regs[ra];
    rd2 = regs[rb];
    if (RFWrite && (regw == ra)) rd1 = dataw;
    if (RFWrite && (regw == rb)) rd2 = dataw;
  end

  // Hazards: a source may have one outstanding write if the bypass covers it now;
  // a destination counter at max may only take a new write if one retires now.
  always_comb begin
    thr_a   = (RFWrite && (regw == ra)) ? CNT_W'(1) : CNT_W'(0);
    thr_b   = (RFWrite && (regw == rb)) ? CNT_W'(1) : CNT_W'(0);
    haz_a   = use_a && (pend[ra] > thr_a);
    haz_b   = use_b && (pend[rb] > thr_b);
    haz_sat = issue_wr && full[issue_rd] && !dec_hit[issue_rd];
    o_stall = issue_valid && (haz_a || haz_b || haz_sat);
  end

  assign accept = issue_valid && !o_stall;

  for (genvar g = 0; g < NREGS; g++) begin : g_cnt
    sb_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .inc       (accept && issue_wr && (issue_rd == AW'(g))),
      .dec_req   (RFWrite && (regw == AW'(g))),
      .cnt       (pend[g]),
      .dec_hit   (dec_hit[g]),
      .full      (full[g]),
      .underflow (underflow[g])
    );
  end

  // Sticky error: any writeback with nothing outstanding for its register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_err <= 1'b0;
    end else if (|underflow) begin
      o_err <= 1'b1;
    end
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, register data width.
REQ-002 The block SHALL have parameter NREGS, default 8, register count; address width is $clog2(NREGS), 3 at default.
REQ-003 The block SHALL have parameter CNT_W, default 2, per-register pending-write counter width.
REQ-004 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1, asynchronous, active-high reset.
REQ-006 Port RFWrite, input, 1, writeback write enable.
REQ-007 Port regw, input, 3, writeback destination register.
REQ-008 Port dataw, input, DATA_W, writeback data.
REQ-009 Port ra and rb, input, 3 each, decode read addresses.
REQ-010 Port use_a and use_b, input, 1 each, decode instruction actually reads ra / rb.
REQ-011 Port issue_valid, input, 1, decode presents an instruction this cycle.
REQ-012 Port issue_wr and issue_rd, input, 1 and 3, issuing instruction writes register issue_rd.
REQ-013 Port rd1 and rd2, output, DATA_W each, read data for ra / rb.
REQ-014 Port o_stall, output, 1, decode must hold; the instruction is not issued.
REQ-015 Port o_err, output, 1, sticky scoreboard underflow flag.

Function
REQ-016 Register write: on a rising edge with RFWrite=1, regs[regw] SHALL take dataw; all other registers are unchanged.
REQ-017 Reads SHALL be combinational with bypass: rd1 = dataw when RFWrite=1 and regw==ra, else regs[ra]; rd2 is the same using rb.
REQ-018 pend[r] SHALL be an unsigned CNT_W-bit count of issued, not-yet-written-back writes to r.
REQ-019 Issue acceptance SHALL be defined as accept = issue_valid & ~o_stall.
REQ-020 pend[r] SHALL increment by 1 when accept & issue_wr & issue_rd==r.
REQ-021 pend[r] SHALL decrement by 1 when RFWrite & regw==r & pend[r]!=0.
REQ-022 When an increment and a decrement coincide on the same r, pend[r] SHALL be unchanged.
REQ-023 A source hazard on ra SHALL be flagged when use_a=1 and pend[ra] exceeds 1 if (RFWrite & regw==ra), else exceeds 0; the bypass covers the last outstanding write.
REQ-024 The rb source hazard SHALL be defined identically using use_b and rb.
REQ-025 A saturation hazard SHALL be flagged when issue_wr=1 and pend[issue_rd]=2^CNT_W-1 (3 at default) and no decrement of issue_rd occurs this cycle.
REQ-026 o_stall SHALL equal issue_valid & (ra hazard | rb hazard | saturation hazard), and SHALL be combinational.
REQ-027 When issue_valid=0, o_stall SHALL be 0 and no counter SHALL increment.
REQ-028 Underflow: if RFWrite=1 and pend[regw]=0, the register write SHALL still occur, pend[regw] SHALL stay 0, and o_err SHALL be set on that edge.
REQ-029 Once set, o_err SHALL stay 1 until reset.

Reset
REQ-030 Asserting reset SHALL immediately clear all regs, all pend, and o_err to 0, independent of clk.
REQ-031 With reset asserted, rd1/rd2 SHALL reflect the cleared registers (0 unless bypassing) and o_stall SHALL be 0 for issue_valid=0.
REQ-032 Reset asserted mid-operation SHALL discard all pending counts; writebacks arriving after release are underflows per REQ-028.

Structure
REQ-033 DATA_W, NREGS and the register-address width constant SHALL reside in definesPkg.
REQ-034 The per-register counter (inc, dec, saturate, underflow detect) SHALL be one sub-module, sb_counter, instantiated NREGS times.

Verification
REQ-035 Write r3=0x1234 via RFWrite, then read ra=3 -> rd1=0x1234 next cycle; with simultaneous RFWrite r3=0xBEEF and ra=3 -> rd1=0xBEEF in the same cycle.
REQ-036 Issue a write to r2 (pend 0->1); next cycle issue with use_a=1, ra=2 and no writeback -> o_stall=1; repeat with RFWrite r2=0x0055 -> o_stall=0 and rd1=0x0055.
REQ-037 Issue three writes to r5 -> pend=3; a fourth issue_wr to r5 -> o_stall=1; the same with RFWrite r5 in that cycle -> accepted and pend stays 3.
REQ-038 Issue to r1 with RFWrite r1 in the same cycle at pend=1 -> pend stays 1.
REQ-039 RFWrite r4=0x00FF with pend[4]=0 -> r4=0x00FF, o_err=1 and remains 1 for later cycles.
REQ-040 Pend r6=2, assert reset between clock edges -> pend, regs and o_err read 0 immediately; a later RFWrite r6 -> o_err=1.
